// File: rtl/asyncio_stream_mover_if.sv
// -----------------------------------------------------------------------------
// asyncio_stream_mover_if
// Purpose : bundles the command channel, the AXI-stream style input/output
//           lanes and the progress/status outputs of asyncio_stream_mover.
// Modports: slave  - the mover (consumes commands and input lanes, drives
//                    output lanes and status)
//           master - the command issuer / stream environment
// Signals : cmd_valid/cmd_ready/cmd_length/cmd_address/cmd_input_id/
//           cmd_output_id/abort, axi_in_valid/axi_in_data/axi_in_ready,
//           axi_out_ready/axi_out_valid/axi_out_data, address_out,
//           length_out, done, cmd_error
// -----------------------------------------------------------------------------
interface asyncio_stream_mover_if #(
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned LENGTH_WIDTH      = 24,
   parameter int unsigned ADDRESS_WIDTH     = 32,
   parameter int unsigned NO_OF_AXI_INPUTS  = 1,
   parameter int unsigned NO_OF_AXI_OUTPUTS = 1
);
   localparam int unsigned INPUT_ID_WIDTH  = (NO_OF_AXI_INPUTS  > 1) ? $clog2(NO_OF_AXI_INPUTS)  : 1;
   localparam int unsigned OUTPUT_ID_WIDTH = (NO_OF_AXI_OUTPUTS > 1) ? $clog2(NO_OF_AXI_OUTPUTS) : 1;

   logic                                      cmd_valid;
   logic                                      cmd_ready;
   logic [LENGTH_WIDTH-1:0]                   cmd_length;
   logic [ADDRESS_WIDTH-1:0]                  cmd_address;
   logic [INPUT_ID_WIDTH-1:0]                 cmd_input_id;
   logic [OUTPUT_ID_WIDTH-1:0]                cmd_output_id;
   logic                                      abort;
   logic [NO_OF_AXI_INPUTS-1:0]               axi_in_valid;
   logic [NO_OF_AXI_INPUTS*DATA_WIDTH-1:0]    axi_in_data;
   logic [NO_OF_AXI_INPUTS-1:0]               axi_in_ready;
   logic [NO_OF_AXI_OUTPUTS-1:0]              axi_out_ready;
   logic [NO_OF_AXI_OUTPUTS-1:0]              axi_out_valid;
   logic [NO_OF_AXI_OUTPUTS*DATA_WIDTH-1:0]   axi_out_data;
   logic [ADDRESS_WIDTH-1:0]                  address_out;
   logic [LENGTH_WIDTH-1:0]                   length_out;
   logic                                      done;
   logic                                      cmd_error;

   modport slave (
      input  cmd_valid, cmd_length, cmd_address, cmd_input_id, cmd_output_id, abort,
      input  axi_in_valid, axi_in_data, axi_out_ready,
      output cmd_ready, axi_in_ready, axi_out_valid, axi_out_data,
      output address_out, length_out, done, cmd_error
   );

   modport master (
      output cmd_valid, cmd_length, cmd_address, cmd_input_id, cmd_output_id, abort,
      output axi_in_valid, axi_in_data, axi_out_ready,
      input  cmd_ready, axi_in_ready, axi_out_valid, axi_out_data,
      input  address_out, length_out, done, cmd_error
   );
endinterface

// File: rtl/asyncio_stream_mover.sv
// -----------------------------------------------------------------------------
// asyncio_stream_mover
// Purpose : moves a commanded number of words from one selected input stream
//           to one selected output stream through a small FIFO, tracking the
//           running byte address and the number of words not yet delivered.
// Ports   : clk   - clock
//           rst_n - asynchronous active-low reset
//           bus   - asyncio_stream_mover_if.slave (command, stream lanes,
//                   address_out/length_out progress, done/cmd_error pulses)
// Config  : define ASYNCIO_ABORT_EN to let abort cancel a running command
//           (FIFO flushed, length_out/address_out hold the residue). Without
//           it the abort input is ignored.
// -----------------------------------------------------------------------------
module asyncio_stream_mover #(
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned FIFO_DEPTH        = 4,
   parameter int unsigned LENGTH_WIDTH      = 24,
   parameter int unsigned ADDRESS_WIDTH     = 32,
   parameter int unsigned NO_OF_AXI_INPUTS  = 1,
   parameter int unsigned NO_OF_AXI_OUTPUTS = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   asyncio_stream_mover_if.slave bus
);
   localparam int unsigned IN_IDW  = (NO_OF_AXI_INPUTS  > 1) ? $clog2(NO_OF_AXI_INPUTS)  : 1;
   localparam int unsigned OUT_IDW = (NO_OF_AXI_OUTPUTS > 1) ? $clog2(NO_OF_AXI_OUTPUTS) : 1;
   localparam int unsigned PTRW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW    = PTRW + 1;

   localparam logic [CNTW-1:0]          DEPTH_C = CNTW'(FIFO_DEPTH);
   localparam logic [IN_IDW:0]          IN_CNT  = (IN_IDW + 1)'(NO_OF_AXI_INPUTS);
   localparam logic [OUT_IDW:0]         OUT_CNT = (OUT_IDW + 1)'(NO_OF_AXI_OUTPUTS);
   localparam logic [ADDRESS_WIDTH-1:0] STRIDE  = ADDRESS_WIDTH'(DATA_WIDTH / 8);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [IN_IDW-1:0]         r_in_id;
   logic [OUT_IDW-1:0]        r_out_id;
   logic [ADDRESS_WIDTH-1:0]  r_address;
   logic [LENGTH_WIDTH-1:0]   r_length;
   logic [LENGTH_WIDTH-1:0]   r_read_left;
   logic                      r_cmd_error;
   logic [DATA_WIDTH-1:0]     r_mem [FIFO_DEPTH];
   logic [PTRW-1:0]           r_wr_ptr;
   logic [PTRW-1:0]           r_rd_ptr;
   logic [CNTW-1:0]           r_count;

   logic [NO_OF_AXI_INPUTS-1:0]  w_in_sel;
   logic [NO_OF_AXI_OUTPUTS-1:0] w_out_sel;
   logic [DATA_WIDTH-1:0]        w_in_data;
   logic [DATA_WIDTH-1:0]        w_head;
   logic                         w_abort;
   logic                         w_id_err;
   logic                         w_accept;
   logic                         w_in_rdy;
   logic                         w_out_vld;
   logic                         w_enq;
   logic                         w_deq;

`ifdef ASYNCIO_ABORT_EN
   assign w_abort = bus.abort && (r_state == S_RUN);
`else
   assign w_abort = bus.abort & 1'b0;
`endif

   assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;
   assign w_id_err = ({1'b0, bus.cmd_input_id}  >= IN_CNT) ||
                     ({1'b0, bus.cmd_output_id} >= OUT_CNT);

   // Lane selection is done via one-hot compare so that single-lane builds
   // never index a 1-bit vector with an id.
   always_comb begin
      w_in_sel  = '0;
      w_in_data = '0;
      for (int unsigned i = 0; i < NO_OF_AXI_INPUTS; i++) begin
         w_in_sel[i] = (32'(r_in_id) == i);
         if (w_in_sel[i]) w_in_data = bus.axi_in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      w_out_sel = '0;
      for (int unsigned i = 0; i < NO_OF_AXI_OUTPUTS; i++) begin
         w_out_sel[i] = (32'(r_out_id) == i);
      end
   end

   assign w_head    = r_mem[r_rd_ptr];
   // No bypass: a word must sit in the FIFO for one cycle before it leaves.
   assign w_in_rdy  = (r_state == S_RUN) && (r_count < DEPTH_C) && (r_read_left != '0) && !w_abort;
   assign w_out_vld = (r_state == S_RUN) && (r_count != '0) && !w_abort;
   assign w_enq     = w_in_rdy  && |(bus.axi_in_valid  & w_in_sel);
   assign w_deq     = w_out_vld && |(bus.axi_out_ready & w_out_sel);

   assign bus.axi_in_ready  = w_in_sel  & {NO_OF_AXI_INPUTS{w_in_rdy}};
   assign bus.axi_out_valid = w_out_sel & {NO_OF_AXI_OUTPUTS{w_out_vld}};

   always_comb begin
      bus.axi_out_data = '0;
      for (int unsigned i = 0; i < NO_OF_AXI_OUTPUTS; i++) begin
         if (w_out_sel[i]) bus.axi_out_data[i*DATA_WIDTH +: DATA_WIDTH] = w_head;
      end
   end

   assign bus.cmd_ready   = (r_state == S_IDLE);
   assign bus.done        = (r_state == S_FINISH);
   assign bus.cmd_error   = r_cmd_error;
   assign bus.address_out = r_address;
   assign bus.length_out  = r_length;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && !w_id_err) w_next = (bus.cmd_length == '0) ? S_FINISH : S_RUN;
         end
         S_RUN: begin
            if (w_abort)                                          w_next = S_FINISH;
            else if (w_deq && (r_length == LENGTH_WIDTH'(1)))     w_next = S_FINISH;
         end
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Storage has no reset; only words covered by r_count are ever observed.
   always_ff @(posedge clk) begin
      if (w_enq) r_mem[r_wr_ptr] <= w_in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_id     <= '0;
         r_out_id    <= '0;
         r_address   <= '0;
         r_length    <= '0;
         r_read_left <= '0;
         r_cmd_error <= 1'b0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
      end else begin
         r_cmd_error <= 1'b0;
         if (w_accept) begin
            r_in_id     <= bus.cmd_input_id;
            r_out_id    <= bus.cmd_output_id;
            r_address   <= bus.cmd_address;
            r_length    <= bus.cmd_length;
            r_read_left <= bus.cmd_length;
            r_cmd_error <= w_id_err;
         end
         if (w_abort) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_enq) begin
               r_wr_ptr    <= r_wr_ptr + PTRW'(1);
               r_read_left <= r_read_left - LENGTH_WIDTH'(1);
            end
            if (w_deq) begin
               r_rd_ptr  <= r_rd_ptr + PTRW'(1);
               r_length  <= r_length - LENGTH_WIDTH'(1);
               r_address <= r_address + STRIDE;
            end
            case ({w_enq, w_deq})
               2'b10:   r_count <= r_count + CNTW'(1);
               2'b01:   r_count <= r_count - CNTW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_asyncio_stream_mover.sv
// -----------------------------------------------------------------------------
// tb_asyncio_stream_mover
// Directed bench for asyncio_stream_mover: 4-deep FIFO, 32-bit words,
// 2 input lanes and 3 output lanes. The source drives every lane valid with
// a distinct word so a wrong lane selection shows up as wrong data.
// -----------------------------------------------------------------------------
module tb_asyncio_stream_mover;
   localparam int unsigned DW   = 32;
   localparam int unsigned NIN  = 2;
   localparam int unsigned NOUT = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   asyncio_stream_mover_if #(
      .DATA_WIDTH(DW), .LENGTH_WIDTH(24), .ADDRESS_WIDTH(32),
      .NO_OF_AXI_INPUTS(NIN), .NO_OF_AXI_OUTPUTS(NOUT)
   ) bus ();

   asyncio_stream_mover #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(4), .LENGTH_WIDTH(24), .ADDRESS_WIDTH(32),
      .NO_OF_AXI_INPUTS(NIN), .NO_OF_AXI_OUTPUTS(NOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int src_sel = 0;
   int dst_sel = 0;
   int sent = 0;
   int rcvd = 0;
   int done_cnt = 0;
   int cmd_no = 0;
   logic [DW-1:0] got [$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] word(input int k);
      return 32'hA500_0000 + (32'(cmd_no) << 16) + 32'(k);
   endfunction

   // One cycle: drive inputs after the falling edge, observe 1ns later,
   // the following rising edge commits whatever handshakes were seen.
   task automatic run_cycle(input bit src_on, input bit snk_on, input bit ab);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.abort     = ab;
      for (int i = 0; i < NIN; i++) bus.axi_in_data[i*DW +: DW] = 32'hDEAD_0000 + 32'(i);
      bus.axi_in_data[src_sel*DW +: DW] = word(sent);
      bus.axi_in_valid  = src_on ? '1 : '0;
      bus.axi_out_ready = snk_on ? '1 : '0;
      #1;
      if (bus.axi_in_ready[src_sel] && bus.axi_in_valid[src_sel]) sent++;
      if (bus.axi_out_valid[dst_sel] && bus.axi_out_ready[dst_sel]) begin
         got.push_back(bus.axi_out_data[dst_sel*DW +: DW]);
         rcvd++;
      end
      if (bus.done) done_cnt++;
   endtask

   task automatic issue(input int len, input logic [31:0] addr, input int iid, input int oid);
      @(negedge clk);
      cmd_no++;
      src_sel = (iid < NIN) ? iid : 0;
      dst_sel = (oid < NOUT) ? oid : 0;
      sent = 0; rcvd = 0; done_cnt = 0;
      got.delete();
      bus.abort         = 1'b0;
      bus.axi_in_valid  = '0;
      bus.axi_out_ready = '0;
      bus.cmd_valid     = 1'b1;
      bus.cmd_length    = 24'(len);
      bus.cmd_address   = addr;
      bus.cmd_input_id  = 1'(iid);
      bus.cmd_output_id = 2'(oid);
      #1;
      chk("cmd_ready_idle", 128'(bus.cmd_ready), 128'(1));
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         run_cycle(1'b1, 1'b1, 1'b0);
         n++;
      end
      chk(tag, 128'(done_cnt != 0), 128'(1));
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_length = '0; bus.cmd_address = '0;
      bus.cmd_input_id = '0; bus.cmd_output_id = '0; bus.abort = 1'b0;
      bus.axi_in_valid = '0; bus.axi_in_data = '0; bus.axi_out_ready = '0;

      // Reset values
      #12;
      chk("rst_cmd_ready", 128'(bus.cmd_ready),     128'(1));
      chk("rst_done",      128'(bus.done),          128'(0));
      chk("rst_cmd_error", 128'(bus.cmd_error),     128'(0));
      chk("rst_in_ready",  128'(bus.axi_in_ready),  128'(0));
      chk("rst_out_valid", 128'(bus.axi_out_valid), 128'(0));
      chk("rst_address",   128'(bus.address_out),   128'(0));
      chk("rst_length",    128'(bus.length_out),    128'(0));
      @(negedge clk); rst_n = 1'b1;

      // len 3 at 0x100, free-flowing source and sink
      issue(3, 32'h100, 0, 0);
      run_until_done("t1_timeout", 20);
      run_cycle(1'b1, 1'b1, 1'b0);
      run_cycle(1'b1, 1'b1, 1'b0);
      chk("t1_rcvd",     128'(rcvd), 128'(3));
      for (int k = 0; k < 3; k++) chk("t1_data", 128'(got[k]), 128'(word(k)));
      chk("t1_address",  128'(bus.address_out), 128'(32'h10C));
      chk("t1_length",   128'(bus.length_out),  128'(0));
      chk("t1_done_cnt", 128'(done_cnt),        128'(1));

      // sink stalled: FIFO fills at 4, then drains without loss
      issue(8, 32'h0, 0, 0);
      for (int k = 0; k < 8; k++) run_cycle(1'b1, 1'b0, 1'b0);
      chk("t2_sent_full", 128'(sent),             128'(4));
      chk("t2_in_ready",  128'(bus.axi_in_ready), 128'(0));
      chk("t2_length",    128'(bus.length_out),   128'(8));
      run_until_done("t2_timeout", 40);
      chk("t2_rcvd", 128'(rcvd), 128'(8));
      for (int k = 0; k < 8; k++) chk("t2_data", 128'(got[k]), 128'(word(k)));
      chk("t2_address", 128'(bus.address_out), 128'(32'h20));

      // lane routing: input 1 to output 0
      issue(2, 32'h40, 1, 0);
      run_cycle(1'b1, 1'b0, 1'b0);
      chk("t3_in_ready_onehot", 128'(bus.axi_in_ready),  128'(2'b10));
      chk("t3_out_valid_empty", 128'(bus.axi_out_valid), 128'(0));
      run_cycle(1'b1, 1'b0, 1'b0);
      chk("t3_out_valid_onehot", 128'(bus.axi_out_valid), 128'(3'b001));
      chk("t3_lane0", 128'(bus.axi_out_data[31:0]),  128'(word(0)));
      chk("t3_lane1", 128'(bus.axi_out_data[63:32]), 128'(0));
      chk("t3_lane2", 128'(bus.axi_out_data[95:64]), 128'(0));
      run_until_done("t3_timeout", 20);
      chk("t3_rcvd", 128'(rcvd), 128'(2));
      chk("t3_data1", 128'(got[1]), 128'(word(1)));

      // zero-length command
      issue(0, 32'h80, 0, 0);
      run_cycle(1'b1, 1'b1, 1'b0);
      chk("t4_done",      128'(bus.done),          128'(1));
      chk("t4_in_ready",  128'(bus.axi_in_ready),  128'(0));
      chk("t4_out_valid", 128'(bus.axi_out_valid), 128'(0));
      run_cycle(1'b1, 1'b1, 1'b0);
      chk("t4_done_clear", 128'(bus.done),      128'(0));
      chk("t4_idle",       128'(bus.cmd_ready), 128'(1));

      // output id out of range
      issue(5, 32'h90, 0, 3);
      run_cycle(1'b1, 1'b1, 1'b0);
      chk("t5_cmd_error", 128'(bus.cmd_error),    128'(1));
      chk("t5_idle",      128'(bus.cmd_ready),    128'(1));
      chk("t5_in_ready",  128'(bus.axi_in_ready), 128'(0));
      run_cycle(1'b1, 1'b1, 1'b0);
      chk("t5_err_clear", 128'(bus.cmd_error), 128'(0));
      chk("t5_no_done",   128'(done_cnt),      128'(0));

      // abort after 2 of 6 words
      issue(6, 32'h200, 0, 0);
      for (int n = 0; n < 20 && rcvd < 2; n++) run_cycle(1'b1, 1'b1, 1'b0);
      chk("t6_two_delivered", 128'(rcvd), 128'(2));
      run_cycle(1'b1, 1'b1, 1'b1);
      chk("t6_len_at_abort", 128'(bus.length_out), 128'(4));
`ifdef ASYNCIO_ABORT_EN
      chk("t6_abort_in_ready",  128'(bus.axi_in_ready),  128'(0));
      chk("t6_abort_out_valid", 128'(bus.axi_out_valid), 128'(0));
      run_cycle(1'b0, 1'b1, 1'b0);
      chk("t6_done",    128'(bus.done),        128'(1));
      chk("t6_length",  128'(bus.length_out),  128'(4));
      chk("t6_address", 128'(bus.address_out), 128'(32'h208));
      chk("t6_rcvd",    128'(rcvd),            128'(2));
      // flushed FIFO: next command sees only its own word
      issue(1, 32'h300, 0, 0);
      run_until_done("t6_next_timeout", 20);
      chk("t6_next_rcvd", 128'(rcvd),   128'(1));
      chk("t6_next_data", 128'(got[0]), 128'(word(0)));
`else
      chk("t6_ignored_in_ready",  128'(bus.axi_in_ready),  128'(2'b01));
      chk("t6_ignored_out_valid", 128'(bus.axi_out_valid), 128'(3'b001));
      run_until_done("t6_timeout", 30);
      chk("t6_rcvd",   128'(rcvd),           128'(6));
      chk("t6_length", 128'(bus.length_out), 128'(0));
      for (int k = 0; k < 6; k++) chk("t6_data", 128'(got[k]), 128'(word(k)));
`endif

      // reset in the middle of a command
      issue(4, 32'h400, 0, 0);
      run_cycle(1'b1, 1'b1, 1'b0);
      run_cycle(1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t7_rst_length",    128'(bus.length_out),    128'(0));
      chk("t7_rst_address",   128'(bus.address_out),   128'(0));
      chk("t7_rst_idle",      128'(bus.cmd_ready),     128'(1));
      chk("t7_rst_out_valid", 128'(bus.axi_out_valid), 128'(0));
      @(negedge clk); rst_n = 1'b1;
      issue(1, 32'h500, 0, 0);
      run_until_done("t7_after_timeout", 20);
      chk("t7_after_data", 128'(got[0]), 128'(word(0)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
